alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator for the multi-cycle ALU core (ports a/b/aluop/output_inc/output_inverted/rst in; done/res_high/res_low out).
//  Accepts one command at a time on a valid/ready interface, latches and drives operands, pulses the ALU restart,
//  waits for done (with timeout), captures the 64-bit result and returns it on a valid/ready response interface.
//  Sits between the test/host command source and the ALU instance in the top level.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before abandoning an op (>=2)
//  CNT_W           16  width of stats counters (used only with ALU_SEQ_STATS_EN)
// PORTS
//  clk              in   1   single clock, all logic rising-edge
//  rst              in   1   asynchronous, active-low reset
//  cmd_valid        in   1   command present
//  cmd_ready        out  1   sequencer can accept command
//  cmd_a            in   32  operand A
//  cmd_b            in   32  operand B
//  cmd_op           in   4   ALU opcode
//  cmd_inc          in   1   value for ALU output_inc during op
//  cmd_inv          in   1   value for ALU output_inverted during op
//  alu_a            out  32  to ALU a
//  alu_b            out  32  to ALU b
//  alu_aluop        out  4   to ALU aluop
//  alu_output_inc   out  1   to ALU output_inc
//  alu_output_inv   out  1   to ALU output_inverted
//  alu_rst          out  1   to ALU rst (active-high restart pulse)
//  alu_done         in   1   from ALU done
//  alu_res_high     in   32  from ALU res_high
//  alu_res_low      in   32  from ALU res_low
//  rsp_valid        out  1   response present
//  rsp_ready        in   1   consumer accepts response
//  rsp_high         out  32  captured res_high (0 on timeout)
//  rsp_low          out  32  captured res_low (0 on timeout)
//  rsp_op           out  4   opcode of this response
//  rsp_timeout      out  1   1 = op abandoned, no done seen
// BEHAVIOUR
//  - FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE. On rst low (any state, mid-op included): state=IDLE, all
//    outputs 0 except cmd_ready=1 once rst released; wait counter cleared; in-flight op dropped silently.
//  - cmd_ready = (state==IDLE). Handshake at cycle T (valid&ready): latch a/b/op/inc/inv; alu_* outputs reflect the
//    latches from T+1 and stay stable until return to IDLE. cmd_* ignored outside IDLE.
//  - LAUNCH: exactly one cycle (T+1), alu_rst=1; alu_done ignored this cycle. Next state WAIT.
//  - WAIT: alu_rst=0; wait counter increments each cycle from 0. alu_done=1 sampled -> capture res_high/low,
//    rsp_timeout=0, go RESP. Counter reaching TIMEOUT_CYCLES-1 with done=0 -> rsp_high/low=0, rsp_timeout=1, RESP.
//    done and timeout in same cycle: done wins.
//  - Min latency: done high in first WAIT cycle (T+2) -> rsp_valid=1 at T+3.
//  - RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1; then IDLE next cycle (cmd_ready=1 again).
//    cmd_valid during RESP is not accepted; no overlap of ops, no response reordering.
//  - rsp_* outputs registered; alu_rst registered (glitch-free). rsp_valid never drops without rsp_ready.
// CONFIGURATION
//  ALU_SEQ_STATS_EN defined: adds outputs stat_ops[CNT_W-1:0] (incr on each RESP handshake with rsp_timeout=0) and
//   stat_timeouts[CNT_W-1:0] (incr on each RESP handshake with rsp_timeout=1); both saturate at all-ones, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (bench drives an ALU model with programmable done delay)
//  - Basic: a=5,b=7,op=4'h2, model done after 3 WAIT cycles with low=35,high=0 -> rsp_low=35,rsp_high=0,rsp_op=2,timeout=0.
//  - Fast done: model done in first WAIT cycle, cmd at T -> alu_rst=1 only at T+1, rsp_valid=1 at T+3.
//  - Timeout: model never raises done -> rsp_valid after TIMEOUT_CYCLES WAIT cycles, rsp_timeout=1, rsp_high=rsp_low=0.
//  - Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0; second cmd_valid accepted only after handshake.
//  - Reset mid-op: rst low during WAIT -> rsp_valid=0, alu_rst=0, cmd_ready=1 after release; next cmd completes normally.
//  - Stats (ALU_SEQ_STATS_EN): 3 good ops + 1 timeout -> stat_ops=3, stat_timeouts=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Single-command initiator for the multi-cycle ALU: launch, bounded wait for done, registered response.
// Optional stats counters are built when ALU_SEQ_STATS_EN is defined.
module alu_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_inc,
  input  logic        cmd_inv,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluop,
  output logic        alu_output_inc,
  output logic        alu_output_inv,
  output logic        alu_rst,
  input  logic        alu_done,
  input  logic [31:0] alu_res_high,
  input  logic [31:0] alu_res_low,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_high,
  output logic [31:0] rsp_low,
  output logic [3:0]  rsp_op,
  output logic        rsp_timeout
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_timeouts
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_param_check
    $error("alu_op_sequencer: TIMEOUT_CYCLES must be >= 2 and CNT_W >= 1");
  end

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [3:0]    r_op;
  logic          r_inc;
  logic          r_inv;
  logic          r_alu_rst;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_high;
  logic [31:0]   r_rsp_low;
  logic [3:0]    r_rsp_op;
  logic          r_rsp_timeout;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_cnt_last;

  assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_fire = r_rsp_valid && rsp_ready;
  assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_inc         <= 1'b0;
      r_inv         <= 1'b0;
      r_alu_rst     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_high    <= '0;
      r_rsp_low     <= '0;
      r_rsp_op      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_a       <= cmd_a;
            r_b       <= cmd_b;
            r_op      <= cmd_op;
            r_inc     <= cmd_inc;
            r_inv     <= cmd_inv;
            r_alu_rst <= 1'b1;
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_alu_rst <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked before the timeout so a late done in the final cycle still counts
          if (alu_done) begin
            r_rsp_high    <= alu_res_high;
            r_rsp_low     <= alu_res_low;
            r_rsp_op      <= r_op;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (w_cnt_last) begin
            r_rsp_high    <= '0;
            r_rsp_low     <= '0;
            r_rsp_op      <= r_op;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [CNT_W-1:0] r_stat_ops;
  logic [CNT_W-1:0] r_stat_timeouts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_ops      <= '0;
      r_stat_timeouts <= '0;
    end else if (w_rsp_fire) begin
      if (r_rsp_timeout) begin
        if (r_stat_timeouts != '1) r_stat_timeouts <= r_stat_timeouts + 1'b1;
      end else begin
        if (r_stat_ops != '1) r_stat_ops <= r_stat_ops + 1'b1;
      end
    end
  end

  assign stat_ops      = r_stat_ops;
  assign stat_timeouts = r_stat_timeouts;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_rsp_fire;
`endif

  // Gated with reset so the host sees no ready while the sequencer is held in reset
  assign cmd_ready      = rst && (r_state == S_IDLE);
  assign alu_a          = r_a;
  assign alu_b          = r_b;
  assign alu_aluop      = r_op;
  assign alu_output_inc = r_inc;
  assign alu_output_inv = r_inv;
  assign alu_rst        = r_alu_rst;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_high       = r_rsp_high;
  assign rsp_low        = r_rsp_low;
  assign rsp_op         = r_rsp_op;
  assign rsp_timeout    = r_rsp_timeout;

endmodule
